// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter among NUM_REQ requesters.
// It latches the winner's byte, holds the grant until tx_done or a watchdog expiry, then releases.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4095,
  parameter int TO_W    = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, SEND, RELEASE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    idx;
  logic [TO_W-1:0]     cnt;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  // Rotate the request vector so that bit 0 is the pointer position, then take the lowest set bit.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   s;
    dbl = {r, r} >> p;
    rot = dbl[NUM_REQ-1:0];
    off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
    return (c == TO_W'(TIMEOUT)) ? c : c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    pick    = rr_pick(req, ptr);
    idx_nxt = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ptr      <= '0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((req != '0) && !tx_busy) begin
            grant    <= NUM_REQ'(1) << pick;
            idx      <= pick;
            tx_data  <= data_arr[pick];
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= SEND;
        end
        SEND: begin
          // Completion takes precedence over a watchdog expiry on the same cycle.
          if (tx_done) begin
            done  <= grant;
            grant <= '0;
            ptr   <= idx_nxt;
            state <= RELEASE;
          end else if (cnt == TO_W'(TIMEOUT)) begin
            err   <= 1'b1;
            grant <= '0;
            ptr   <= idx_nxt;
            state <= RELEASE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RELEASE: begin
          done  <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by randomized transfers
// checked against a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TO  = 15;
  localparam int TOW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            err;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .TO_W    (TOW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the start strobe, then check grant, latched byte and optionally latency.
  task automatic expect_start(input logic [N-1:0] eg, input logic [DW-1:0] ed,
                              input int lat, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_start !== 1'b1 && k < 200);
    chk({tag, "_started"}, {31'd0, tx_start}, 32'd1);
    if (lat > 0) chk({tag, "_latency"}, k, lat);
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, eg});
    chk({tag, "_txdata"}, {24'd0, tx_data}, {24'd0, ed});
  endtask

  // Called on the negedge where tx_start was seen; ends the transfer by tx_done or watchdog.
  task automatic finish_xfer(input logic [N-1:0] eg, input logic [DW-1:0] ed,
                             input int dly, input bit to, input string tag);
    int k;
    if (!to) begin
      repeat (dly) @(negedge clk);
      chk({tag, "_send_data"}, {24'd0, tx_data}, {24'd0, ed});
      chk({tag, "_send_grant"}, {28'd0, grant}, {28'd0, eg});
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk({tag, "_done"}, {28'd0, done}, {28'd0, eg});
      chk({tag, "_no_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_grant_off"}, {28'd0, grant}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_clr"}, {28'd0, done}, 32'd0);
    end else begin
      @(negedge clk);
      k = 1;
      chk({tag, "_send_data"}, {24'd0, tx_data}, {24'd0, ed});
      while (err !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_err"}, {31'd0, err}, 32'd1);
      chk({tag, "_err_time"}, k, TO + 2);
      chk({tag, "_err_no_done"}, {28'd0, done}, 32'd0);
      chk({tag, "_err_grant_off"}, {28'd0, grant}, 32'd0);
      @(negedge clk);
      chk({tag, "_err_clr"}, {31'd0, err}, 32'd0);
    end
  endtask

  logic [DW-1:0] b [N];
  logic [N-1:0]  r;
  logic [N-1:0]  eg;
  int            ptr_m;
  int            win;
  bit            found;
  bit            to;
  int            dly;

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin with all four requesting continuously.
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_start(4'b0001 << (i % 4), 8'((i % 4 + 1) * 16), 1, "rr");
      if (i == 4) req = 4'b0000;
      finish_xfer(4'b0001 << (i % 4), 8'((i % 4 + 1) * 16), 3 + i, 1'b0, "rr");
    end

    // Single requester.
    req_data = {8'h44, 8'h33, 8'h22, 8'h41};
    req      = 4'b0001;
    expect_start(4'b0001, 8'h41, 1, "single");
    req = 4'b0000;
    finish_xfer(4'b0001, 8'h41, 12, 1'b0, "single");

    // Busy line blocks arbitration.
    tx_busy = 1'b1;
    req     = 4'b0010;
    repeat (5) @(negedge clk);
    chk("busy_no_grant", {28'd0, grant}, 32'd0);
    chk("busy_no_start", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b0;
    expect_start(4'b0010, 8'h22, 1, "busy");
    req = 4'b0000;
    finish_xfer(4'b0010, 8'h22, 4, 1'b0, "busy");

    // Watchdog abort, then the other pending requester is served; req_data changes are ignored.
    req = 4'b0101;
    expect_start(4'b0100, 8'h33, 1, "wdog");
    req      = 4'b0001;
    req_data = {8'h44, 8'hEE, 8'h22, 8'h41};
    finish_xfer(4'b0100, 8'h33, 0, 1'b1, "wdog");
    expect_start(4'b0001, 8'h41, 1, "after_wdog");
    req = 4'b0000;
    finish_xfer(4'b0001, 8'h41, 5, 1'b0, "after_wdog");

    // tx_done on the very cycle the watchdog would fire.
    req = 4'b0010;
    expect_start(4'b0010, 8'h22, 1, "collide");
    req = 4'b0000;
    finish_xfer(4'b0010, 8'h22, TO + 1, 1'b0, "collide");

    // Asynchronous reset in the middle of a transfer.
    req = 4'b0010;
    expect_start(4'b0010, 8'h22, 1, "mid_rst");
    req = 4'b0000;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", {28'd0, done}, 32'd0);
    chk("mid_rst_no_err", {31'd0, err}, 32'd0);
    req = 4'b1010;
    expect_start(4'b0010, 8'h22, 1, "post_rst");
    req = 4'b0000;
    finish_xfer(4'b0010, 8'h22, 6, 1'b0, "post_rst");

    // Randomized transfers against the round-robin reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ptr_m = 0;
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) b[i] = 8'($urandom);
      req_data = {b[3], b[2], b[1], b[0]};
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && (((r >> ((ptr_m + k) % N)) & 4'b0001) != 4'b0000)) begin
          win   = (ptr_m + k) % N;
          found = 1'b1;
        end
      end
      eg  = 4'b0001 << win;
      req = r;
      expect_start(eg, b[win[1:0]], 1, "rnd");
      req      = 4'($urandom_range(0, 15));
      req_data = $urandom;
      to  = ($urandom_range(0, 4) == 0);
      dly = $urandom_range(1, TO + 1);
      finish_xfer(eg, b[win[1:0]], dly, to, "rnd");
      ptr_m = (win + 1) % N;
    end
    req = 4'b0000;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
